// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-locking arbiter that shares one UART_TX
//               byte port between N_REQ byte-stream requesters. The grant is
//               held until the owner's last byte is accepted or the owner
//               stays idle long enough to trip the idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int TIMEOUT_CLKS = 86900
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_byte,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_byte,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 timeout
);

    localparam int c_IDX_W   = $clog2(N_REQ);
    // A zero timeout disables the timer; keep it one bit wide so it stays legal.
    localparam int c_TIMER_W = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LIM =
        (TIMEOUT_CLKS > 0) ? c_TIMER_W'(TIMEOUT_CLKS - 1) : '0;
    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = '1;
    localparam bit   c_TIMEOUT_EN = (TIMEOUT_CLKS > 0);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_LOCK = 1'b1;

    logic [0:0]           r_state;
    logic [N_REQ-1:0]     r_grant;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_timeout;

    logic                 w_pick_found;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic [N_REQ-1:0]     w_pick_onehot;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_locked;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic                 w_xfer;
    logic                 w_expire;

    // Round-robin search: first valid requester starting just after the pointer.
    always_comb begin
        w_pick_found  = 1'b0;
        w_pick_idx    = '0;
        w_pick_onehot = '0;
        w_cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = c_IDX_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_pick_found && req_valid[w_cand]) begin
                w_pick_found          = 1'b1;
                w_pick_idx            = w_cand;
                w_pick_onehot         = '0;
                w_pick_onehot[w_cand] = 1'b1;
            end
        end
    end

    assign w_locked    = (r_state == c_ST_LOCK);
    assign w_own_valid = req_valid[r_owner];
    assign w_own_last  = req_last[r_owner];
    assign w_xfer      = w_locked && w_own_valid && tx_ready;
    // Only owner idleness counts; a stalled-but-valid owner keeps the timer clear.
    assign w_expire    = c_TIMEOUT_EN && w_locked && !w_own_valid &&
                         (r_timer == c_TIMER_LIM);

    // Data path is a pure mux of the owner's stream so the first byte can
    // move in the very first locked cycle.
    assign tx_valid  = w_locked && w_own_valid;
    assign tx_byte   = w_locked ? req_byte[{r_owner, 3'b000} +: 8] : 8'h00;
    assign req_ready = w_locked ? (r_grant & {N_REQ{tx_ready}}) : '0;
    assign grant     = r_grant;
    assign timeout   = r_timeout;

    // Arbitration FSM: grant selection, packet lock, idle timer and release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_ptr     <= c_IDX_W'(N_REQ - 1);
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_timer <= '0;
                    if (w_pick_found) begin
                        r_state <= c_ST_LOCK;
                        r_owner <= w_pick_idx;
                        r_grant <= w_pick_onehot;
                    end
                end
                c_ST_LOCK: begin
                    if (w_xfer && w_own_last) begin
                        r_state <= c_ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= r_owner;
                        r_timer <= '0;
                    end else if (w_own_valid) begin
                        r_timer <= '0;
                    end else if (w_expire) begin
                        r_state   <= c_ST_IDLE;
                        r_grant   <= '0;
                        r_ptr     <= r_owner;
                        r_timer   <= '0;
                        r_timeout <= 1'b1;
                    end else if (r_timer != c_TIMER_MAX) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_grant <= '0;
                    r_timer <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed, table-driven bench for uart_tx_arbiter (N_REQ=2,
//               TIMEOUT_CLKS=8) with hand sequences for multi-cycle cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic       rst_n;
        logic [1:0] v;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [1:0] l;
        logic       rdy;
        logic [1:0] e_g;
        logic       e_txv;
        logic [7:0] e_txb;
        logic [1:0] e_rdy;
        logic       e_to;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_byte;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  grant;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .N_REQ        (2),
        .TIMEOUT_CLKS (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_byte  (req_byte),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [1:0] l, input logic rdy,
                                input logic [1:0] eg, input logic etxv, input logic [7:0] etxb,
                                input logic [1:0] erdy, input logic eto);
        vec_t x;
        x.rst_n = r;  x.v = v;   x.b0 = b0;  x.b1 = b1;  x.l = l;  x.rdy = rdy;
        x.e_g = eg;   x.e_txv = etxv;  x.e_txb = etxb;  x.e_rdy = erdy;  x.e_to = eto;
        return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector, compare outputs mid-cycle, then advance one clock.
    task automatic apply(input vec_t x, input string tag);
        rst_n     = x.rst_n;
        req_valid = x.v;
        req_byte  = {x.b1, x.b0};
        req_last  = x.l;
        tx_ready  = x.rdy;
        #2;
        chk({tag, ".grant"},     {6'd0, grant},     {6'd0, x.e_g});
        chk({tag, ".tx_valid"},  {7'd0, tx_valid},  {7'd0, x.e_txv});
        chk({tag, ".tx_byte"},   tx_byte,           x.e_txb);
        chk({tag, ".req_ready"}, {6'd0, req_ready}, {6'd0, x.e_rdy});
        chk({tag, ".timeout"},   {7'd0, timeout},   {7'd0, x.e_to});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];

        // Reset held with both requesters valid, then release.
        tbl.push_back(mk(0, 2'b11, 8'h41, 8'h50, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 2'b11, 8'h41, 8'h50, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 2'b11, 8'h41, 8'h50, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(1, 2'b11, 8'h41, 8'h50, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0));
        // req0 packet 41/42/43 while req1 waits locked out.
        tbl.push_back(mk(1, 2'b11, 8'h41, 8'h50, 2'b00, 1, 2'b01, 1, 8'h41, 2'b01, 0));
        tbl.push_back(mk(1, 2'b11, 8'h42, 8'h50, 2'b00, 1, 2'b01, 1, 8'h42, 2'b01, 0));
        tbl.push_back(mk(1, 2'b11, 8'h43, 8'h50, 2'b01, 1, 2'b01, 1, 8'h43, 2'b01, 0));
        // Round robin with 2-byte packets: 10, 01, 10.
        tbl.push_back(mk(1, 2'b11, 8'h60, 8'h50, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(1, 2'b11, 8'h60, 8'h50, 2'b00, 1, 2'b10, 1, 8'h50, 2'b10, 0));
        tbl.push_back(mk(1, 2'b11, 8'h60, 8'h51, 2'b10, 1, 2'b10, 1, 8'h51, 2'b10, 0));
        tbl.push_back(mk(1, 2'b11, 8'h60, 8'h52, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(1, 2'b11, 8'h60, 8'h52, 2'b00, 1, 2'b01, 1, 8'h60, 2'b01, 0));
        tbl.push_back(mk(1, 2'b11, 8'h61, 8'h52, 2'b01, 1, 2'b01, 1, 8'h61, 2'b01, 0));
        tbl.push_back(mk(1, 2'b11, 8'h62, 8'h52, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(1, 2'b11, 8'h62, 8'h52, 2'b00, 1, 2'b10, 1, 8'h52, 2'b10, 0));
        tbl.push_back(mk(1, 2'b11, 8'h62, 8'h53, 2'b10, 1, 2'b10, 1, 8'h53, 2'b10, 0));
        tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0));

        rst_n = 1'b0;  req_valid = '0;  req_byte = '0;  req_last = '0;  tx_ready = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: 20 stalled clocks with timeout=8 must not release the lock.
        apply(mk(1, 2'b01, 8'h70, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0), "bp.sel");
        apply(mk(1, 2'b01, 8'h70, 8'h00, 2'b00, 1, 2'b01, 1, 8'h70, 2'b01, 0), "bp.b0");
        for (int i = 0; i < 20; i++)
            apply(mk(1, 2'b01, 8'h71, 8'h00, 2'b01, 0, 2'b01, 1, 8'h71, 2'b00, 0),
                  $sformatf("bp.stall%0d", i));
        apply(mk(1, 2'b01, 8'h71, 8'h00, 2'b01, 1, 2'b01, 1, 8'h71, 2'b01, 0), "bp.last");

        // Timeout: req1 sends one byte then goes quiet; req0 pending behind it.
        apply(mk(1, 2'b10, 8'h00, 8'h80, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0), "to.sel");
        apply(mk(1, 2'b10, 8'h00, 8'h80, 2'b00, 1, 2'b10, 1, 8'h80, 2'b10, 0), "to.b0");
        for (int i = 0; i < 8; i++)
            apply(mk(1, 2'b01, 8'h90, 8'h81, 2'b01, 1, 2'b10, 0, 8'h81, 2'b10, 0),
                  $sformatf("to.idle%0d", i));
        apply(mk(1, 2'b01, 8'h90, 8'h81, 2'b01, 1, 2'b00, 0, 8'h00, 2'b00, 1), "to.pulse");
        apply(mk(1, 2'b01, 8'h90, 8'h81, 2'b01, 1, 2'b01, 1, 8'h90, 2'b01, 0), "to.req0");
        apply(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0), "to.done");

        // Reset mid-packet: the rest of the packet is granted afresh afterwards.
        apply(mk(1, 2'b01, 8'hA0, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0), "rm.sel");
        apply(mk(1, 2'b01, 8'hA0, 8'h00, 2'b00, 1, 2'b01, 1, 8'hA0, 2'b01, 0), "rm.b0");
        apply(mk(0, 2'b01, 8'hA1, 8'h00, 2'b01, 1, 2'b01, 1, 8'hA1, 2'b01, 0), "rm.rst");
        apply(mk(1, 2'b01, 8'hA1, 8'h00, 2'b01, 1, 2'b00, 0, 8'h00, 2'b00, 0), "rm.resel");
        apply(mk(1, 2'b01, 8'hA1, 8'h00, 2'b01, 1, 2'b01, 1, 8'hA1, 2'b01, 0), "rm.b1");
        apply(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0), "rm.done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
